// File: rtl/spi_exec_cluster_if.sv
// SPI bus bundle shared between the core (SPI master) and the execution cluster.
//   nss  : active-low frame select, master to slave
//   sclk : SPI clock, mode 0 (idle low), master to slave
//   mosi : master-to-slave data, MSB first
//   miso : slave-to-master data, MSB first
interface spi_exec_cluster_if;
   logic nss;
   logic sclk;
   logic mosi;
   logic miso;

   // The core drives the frame and samples the returned result
   modport master (output nss, output sclk, output mosi, input miso);

   // The cluster receives the frame and drives back the result
   modport slave  (input nss, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_exec_cluster.sv
// SPI-slave execution cluster: receives an opcode and two operands over one
// SPI frame, runs them through an ALU (ADD/SUB/AND) or a barrel shifter
// (SHL/SHR/SRA/ROL), and returns the result within the same frame.
// Opcode 011 belongs to the multiplier on the same bus and is left alone.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   spi   : slave modport of spi_exec_cluster_if (nss, sclk, mosi in; miso out)
module spi_exec_cluster #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   spi_exec_cluster_if.slave   spi
);

   localparam int SHAMT_W    = $clog2(DATA_W);
   localparam int IN_BITS    = 8 + 2 * DATA_W;
   localparam int FRAME_BITS = IN_BITS + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      EXEC,
      SHIFT_OUT,
      DONE
   } stateType;

   stateType              state;
   logic [CNT_W-1:0]      bitCount;
   logic [7:0]            cmdReg;
   logic [DATA_W-1:0]     opA;
   logic [DATA_W-1:0]     opB;
   logic [DATA_W-1:0]     result;
   logic                  misoReg;

   logic [SYNC_STAGES-1:0] nssSync;
   logic [SYNC_STAGES-1:0] sclkSync;
   logic [SYNC_STAGES-1:0] mosiSync;
   logic                   nssPrev;
   logic                   sclkPrev;

   logic                   nssS;
   logic                   sclkS;
   logic                   mosiS;
   logic                   sclkRise;
   logic                   sclkFall;
   logic                   nssFall;

   logic [2:0]             opcode;
   logic [SHAMT_W-1:0]     shamt;
   logic                   ownedOp;
   logic [DATA_W-1:0]      execY;
   logic [2*DATA_W-1:0]    rotWide;

   // Bring the SPI pins into the clock domain. nss resets to its idle (high)
   // level so a frame can only start from a genuine falling edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nssSync  <= '1;
         sclkSync <= '0;
         mosiSync <= '0;
         nssPrev  <= 1'b1;
         sclkPrev <= 1'b0;
      end else begin
         nssSync  <= {nssSync[SYNC_STAGES-2:0], spi.nss};
         sclkSync <= {sclkSync[SYNC_STAGES-2:0], spi.sclk};
         mosiSync <= {mosiSync[SYNC_STAGES-2:0], spi.mosi};
         nssPrev  <= nssSync[SYNC_STAGES-1];
         sclkPrev <= sclkSync[SYNC_STAGES-1];
      end
   end

   // mosi travels through the same number of flops as sclk, so the sample
   // seen alongside a detected rising edge is the bit the master presented.
   always_comb begin
      nssS     = nssSync[SYNC_STAGES-1];
      sclkS    = sclkSync[SYNC_STAGES-1];
      mosiS    = mosiSync[SYNC_STAGES-1];
      sclkRise = sclkS & ~sclkPrev;
      sclkFall = ~sclkS & sclkPrev;
      nssFall  = ~nssS & nssPrev;
   end

   // ALU and barrel shifter share one result mux. Rotation is done by
   // shifting a doubled copy of A so a zero rotate needs no special case.
   always_comb begin
      opcode  = cmdReg[7:5];
      shamt   = opB[SHAMT_W-1:0];
      ownedOp = (opcode != 3'b011);
      rotWide = {opA, opA} << shamt;
      execY   = '0;
      case (opcode)
         3'b000:  execY = opA + opB;
         3'b001:  execY = opA - opB;
         3'b010:  execY = opA & opB;
         3'b100:  execY = opA << shamt;
         3'b101:  execY = opA >> shamt;
         3'b110:  execY = DATA_W'($signed(opA) >>> shamt);
         3'b111:  execY = rotWide[2*DATA_W-1:DATA_W];
         default: execY = '0;
      endcase
   end

   // Frame sequencer. Command and operands form one long shift chain, so
   // after the last input bit the command byte sits at the top of cmdReg.
   // The result register doubles as the output shifter; miso is updated only
   // on falling sclk edges so it is stable when the master samples on rising.
   // nss going high in any active state abandons the frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bitCount <= '0;
         cmdReg   <= '0;
         opA      <= '0;
         opB      <= '0;
         result   <= '0;
         misoReg  <= 1'b0;
      end else if (state != IDLE && nssS) begin
         state    <= IDLE;
         bitCount <= '0;
         misoReg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               misoReg <= 1'b0;
               if (nssFall) begin
                  state    <= SHIFT_IN;
                  bitCount <= '0;
               end
            end
            SHIFT_IN: begin
               if (sclkRise) begin
                  cmdReg   <= {cmdReg[6:0], opA[DATA_W-1]};
                  opA      <= {opA[DATA_W-2:0], opB[DATA_W-1]};
                  opB      <= {opB[DATA_W-2:0], mosiS};
                  bitCount <= bitCount + 1'b1;
                  if (bitCount == CNT_W'(IN_BITS - 1)) begin
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (ownedOp) begin
                  result <= execY;
                  state  <= SHIFT_OUT;
               end else begin
                  state  <= DONE;
               end
            end
            SHIFT_OUT: begin
               if (sclkFall) begin
                  misoReg <= result[DATA_W-1];
                  result  <= {result[DATA_W-2:0], 1'b0};
               end
               if (sclkRise) begin
                  bitCount <= bitCount + 1'b1;
                  if (bitCount == CNT_W'(FRAME_BITS - 1)) begin
                     state   <= DONE;
                     misoReg <= 1'b0;
                  end
               end
            end
            DONE: begin
               misoReg <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               misoReg <= 1'b0;
            end
         endcase
      end
   end

   assign spi.miso = misoReg;

endmodule

// File: tb/tb_spi_exec_cluster.sv
// Directed bench for spi_exec_cluster: plays SPI master, sends full and
// truncated frames, and checks the returned result words against
// hand-computed values.
module tb_spi_exec_cluster;

   localparam int HALF = 6;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   spi_exec_cluster_if bus ();

   spi_exec_cluster #(
      .DATA_W      (32),
      .SYNC_STAGES (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .spi   (bus)
   );

   // 100 MHz system clock
   always #5 clock = ~clock;

   // Guard against a stuck run
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Master side of one frame: drives nBits bits, collects miso for bits
   // 72 onward, and flags any nonzero miso seen during the input phase.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, input int nBits,
                                input bit endFrame, output logic [31:0] rxWord,
                                output bit earlyMiso);
      logic [103:0] frame;
      frame     = {cmd, a, b, 32'h0};
      rxWord    = '0;
      earlyMiso = 1'b0;
      @(negedge clock);
      bus.nss = 1'b0;
      waitClocks(HALF);
      for (int i = 0; i < nBits; i++) begin
         bus.mosi = frame[103-i];
         waitClocks(HALF);
         if (i >= 72) rxWord = {rxWord[30:0], bus.miso};
         else if (bus.miso !== 1'b0) earlyMiso = 1'b1;
         bus.sclk = 1'b1;
         waitClocks(HALF);
         bus.sclk = 1'b0;
      end
      bus.mosi = 1'b0;
      if (endFrame) begin
         waitClocks(HALF);
         bus.nss = 1'b1;
         waitClocks(HALF + 2);
      end
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      bus.nss  = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      waitClocks(3);
      total++;
      if (bus.miso !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_hold: got %b want 0", bus.miso);
      end
      reset = 1'b0;
      waitClocks(4);
      total++;
      if (bus.miso !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release: got %b want 0", bus.miso);
      end
   endtask

   task automatic test_alu;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h00, 32'd10, 32'd20, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h0000001E) begin
         bad++;
         $display("[TB] FAIL add: got %h want 0000001e", rx);
      end
      applyStimulus(8'h20, 32'd0, 32'd1, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'hFFFFFFFF) begin
         bad++;
         $display("[TB] FAIL sub_wrap: got %h want ffffffff", rx);
      end
   endtask

   task automatic test_shifter;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h80, 32'd300, 32'd2, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h000004B0) begin
         bad++;
         $display("[TB] FAIL shl: got %h want 000004b0", rx);
      end
      applyStimulus(8'h80, 32'd300, 32'h00000022, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h000004B0) begin
         bad++;
         $display("[TB] FAIL shl_amount_mask: got %h want 000004b0", rx);
      end
      applyStimulus(8'hC0, 32'h80000000, 32'd4, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'hF8000000) begin
         bad++;
         $display("[TB] FAIL sra: got %h want f8000000", rx);
      end
      applyStimulus(8'hA0, 32'h80000000, 32'd4, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h08000000) begin
         bad++;
         $display("[TB] FAIL shr: got %h want 08000000", rx);
      end
      applyStimulus(8'hE0, 32'h80000001, 32'd1, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h00000003) begin
         bad++;
         $display("[TB] FAIL rol: got %h want 00000003", rx);
      end
   endtask

   task automatic test_foreign;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h60, 32'd30, 32'd10, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h0 || early !== 1'b0) begin
         bad++;
         $display("[TB] FAIL foreign_quiet: got %h early=%b want 00000000 early=0", rx, early);
      end
      applyStimulus(8'h00, 32'd100, 32'd23, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h0000007B) begin
         bad++;
         $display("[TB] FAIL add_after_foreign: got %h want 0000007b", rx);
      end
   endtask

   task automatic test_abort;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h20, 32'hDEADBEEF, 32'h11111111, 40, 1'b1, rx, early);
      total++;
      if (early !== 1'b0 || bus.miso !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_quiet: got early=%b miso=%b want 0 0", early, bus.miso);
      end
      applyStimulus(8'h00, 32'd7, 32'd5, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h0000000C) begin
         bad++;
         $display("[TB] FAIL add_after_abort: got %h want 0000000c", rx);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h40, 32'hF0F0F0F0, 32'h0FF00FF0, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h00F000F0) begin
         bad++;
         $display("[TB] FAIL and_b2b: got %h want 00f000f0", rx);
      end
      applyStimulus(8'hFF, 32'h12345678, 32'h00000020, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL rol_zero_b2b: got %h want 12345678", rx);
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] rx;
      bit          early;
      applyStimulus(8'h20, 32'd0, 32'd1, 80, 1'b0, rx, early);
      waitClocks(HALF);
      total++;
      if (bus.miso !== 1'b1) begin
         bad++;
         $display("[TB] FAIL shift_out_before_reset: got %b want 1", bus.miso);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      total++;
      if (bus.miso !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset_miso: got %b want 0", bus.miso);
      end
      waitClocks(2);
      bus.nss = 1'b1;
      reset   = 1'b0;
      waitClocks(HALF + 2);
      applyStimulus(8'h00, 32'd7, 32'd5, 104, 1'b1, rx, early);
      total++;
      if (rx !== 32'h0000000C) begin
         bad++;
         $display("[TB] FAIL add_after_reset: got %h want 0000000c", rx);
      end
   endtask

   initial begin
      $display("[TB] starting spi_exec_cluster bench");
      test_reset();
      test_alu();
      test_shifter();
      test_foreign();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
